// File: rtl/icache_fifo_sched_pkg.sv
// +--------------------------------------------------------------------------+
// | icache_pkg : shared types and default sizes for the icache FIFO scheduler |
// | Revision   : 1.0                                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

package icache_pkg;

  localparam int c_num_req        = 4;
  localparam int c_data_w         = 32;
  localparam int c_id_w           = 2;
  localparam int c_fifo_depth     = 8;
  localparam int c_fifo_depth_bit = 3;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fsched_state_e;

  // Packed FIFO word at the default sizes: {src_id, payload}.
  typedef struct packed {
    logic [c_id_w-1:0]   src_id;
    logic [c_data_w-1:0] payload;
  } fifo_entry_t;

endpackage

`default_nettype wire

// File: rtl/icache_fifo_sched_rr_arbiter.sv
// +--------------------------------------------------------------------------+
// | rr_arbiter : round-robin pick of the first valid index starting at ptr    |
// | Revision   : 1.0                                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  // Scan from the farthest offset back to ptr so the nearest valid one wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (valid[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = ID_W'(j);
        any      = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/icache_fifo_sched.sv
// +--------------------------------------------------------------------------+
// | icache_fifo_sched : round-robin writer, read sequencer and flush control  |
// |                     around an external icache sync FIFO                   |
// | Revision          : 1.0                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module icache_fifo_sched
  import icache_pkg::*;
#(
  parameter int NUM_REQ        = c_num_req,
  parameter int DATA_W         = c_data_w,
  parameter int ID_W           = c_id_w,
  parameter int FIFO_DEPTH     = c_fifo_depth,
  parameter int FIFO_DEPTH_BIT = c_fifo_depth_bit
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      fifo_w_en,
  output logic [ID_W+DATA_W-1:0]    fifo_data_write,
  output logic                      fifo_r_en,
  input  logic                      fifo_flag_empty,
  input  logic [ID_W+DATA_W-1:0]    fifo_data_read,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [ID_W-1:0]           out_src_id,
  input  logic                      flush,
  output logic                      flush_done,
  output logic [FIFO_DEPTH_BIT:0]   occupancy
);

  localparam logic [FIFO_DEPTH_BIT:0] c_depth = (FIFO_DEPTH_BIT + 1)'(FIFO_DEPTH);
  localparam logic [ID_W-1:0]         c_last  = ID_W'(NUM_REQ - 1);

  fsched_state_e           r_state;
  fsched_state_e           w_state_nxt;
  logic [FIFO_DEPTH_BIT:0] r_cnt;
  logic [ID_W-1:0]         r_rr_ptr;
  logic                    r_out_valid;
  logic                    r_flush_done;

  logic [NUM_REQ-1:0]      w_grant;
  logic [ID_W-1:0]         w_gidx;
  logic                    w_any;
  logic                    w_can_wr;
  logic                    w_wr;
  logic                    w_rd;
  logic                    w_flush_finish;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .valid (req_valid),
    .ptr   (r_rr_ptr),
    .grant (w_grant),
    .idx   (w_gidx),
    .any   (w_any)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (flush) w_state_nxt = FLUSH;
      FLUSH:   if (r_cnt == '0) w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  // A pop in this cycle never frees room for a push in the same cycle.
  always_comb begin
    w_can_wr       = 1'b0;
    w_rd           = 1'b0;
    w_flush_finish = 1'b0;
    if (rst_n) begin
      case (r_state)
        RUN: begin
          w_can_wr = !flush && (r_cnt < c_depth);
          w_rd     = !flush && (r_cnt != '0) && (!r_out_valid || out_ready);
        end
        FLUSH: begin
          w_rd           = (r_cnt != '0);
          w_flush_finish = (r_cnt == '0);
        end
        default: ;
      endcase
    end
    w_wr = w_can_wr && w_any;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_rr_ptr     <= '0;
      r_out_valid  <= 1'b0;
      r_flush_done <= 1'b0;
    end else begin
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      if (w_wr) r_rr_ptr <= (w_gidx == c_last) ? '0 : w_gidx + 1'b1;
      // Flush entry and the flush itself discard any held output.
      r_out_valid  <= (r_state == RUN) && !flush && (w_rd || (r_out_valid && !out_ready));
      r_flush_done <= w_flush_finish;
    end
  end

  assign req_ready       = w_can_wr ? w_grant : '0;
  assign fifo_w_en       = w_wr;
  assign fifo_data_write = rst_n ? {w_gidx, req_data[int'(w_gidx)*DATA_W +: DATA_W]} : '0;
  assign fifo_r_en       = w_rd;
  assign out_valid       = r_out_valid;
  assign out_data        = fifo_data_read[DATA_W-1:0];
  assign out_src_id      = fifo_data_read[ID_W+DATA_W-1:DATA_W];
  assign flush_done      = r_flush_done;
  assign occupancy       = r_cnt;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n) begin
      assert (fifo_flag_empty == (r_cnt == '0))
        else $error("fifo empty flag disagrees with occupancy %0d", r_cnt);
      assert (r_cnt <= c_depth) else $error("occupancy overflow %0d", r_cnt);
      assert (!(w_rd && r_cnt == '0)) else $error("read issued with occupancy 0");
      assert ($onehot0(req_ready)) else $error("req_ready not one-hot %b", req_ready);
    end
  end
`endif

endmodule

`default_nettype wire
